// File: rtl/div4_issue_stage.sv
// -----------------------------------------------------------------------------
// div4_issue_stage
//   Sequential issue/collect stage around an external 4-bit combinational
//   divider. Operand pairs arrive on a valid/ready handshake and are registered
//   onto the divider inputs. One cycle later the divider result is captured
//   into a show-ahead result FIFO. Results leave in order on a second
//   valid/ready handshake. Divide-by-zero is detected here; the divider output
//   for that case is ignored.
//
// Ports
//   i_clk, i_rst_n         clock (rising edge), async active-low reset
//   i_in_valid/o_in_ready  operand handshake; i_in_a dividend, i_in_b divisor
//   o_div_a/o_div_b        registered operands to the divider
//   i_div_q/i_div_r        divider quotient/remainder (combinational)
//   o_out_valid/i_out_ready result handshake; o_out_q, o_out_r, o_out_dbz
//   o_dbz_cnt              saturating count of accepted divide-by-zero pairs
// -----------------------------------------------------------------------------
module div4_issue_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_in_a,
  input  logic [3:0]       i_in_b,
  output logic [3:0]       o_div_a,
  output logic [3:0]       o_div_b,
  input  logic [3:0]       i_div_q,
  input  logic [3:0]       i_div_r,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [3:0]       o_out_q,
  output logic [3:0]       o_out_r,
  output logic             o_out_dbz,
  output logic [CNT_W-1:0] o_dbz_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] DBZ_MAX = {CNT_W{1'b1}};

  // Build a FIFO entry {q, r, dbz}; a zero divisor overrides the divider.
  function automatic logic [8:0] f_collect(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] q, input logic [3:0] r);
    logic [8:0] e;
    if (b == 4'd0) begin
      e = {4'hF, a, 1'b1};
    end else begin
      e = {q, r, 1'b0};
    end
    return e;
  endfunction

  // Saturating increment for the divide-by-zero event counter.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] n;
    if (v == DBZ_MAX) begin
      n = v;
    end else begin
      n = v + CNT_W'(1);
    end
    return n;
  endfunction

  logic             r_s1_valid;
  logic [3:0]       r_div_a;
  logic [3:0]       r_div_b;
  logic [8:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic [CNT_W-1:0] r_dbz_cnt;

  logic [OCC_W-1:0] w_occupancy;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_out_valid;
  logic [8:0]       w_entry;
  logic [8:0]       w_head;

  // Occupancy counts the in-flight pair so its FIFO slot is always reserved;
  // this is what makes overflow impossible without a full-check on push.
  assign w_occupancy = r_count + {{PTR_W{1'b0}}, r_s1_valid};
  assign w_in_ready  = (w_occupancy < DEPTH_C);
  assign w_accept    = i_in_valid & w_in_ready;
  assign w_push      = r_s1_valid;
  assign w_out_valid = (r_count != {OCC_W{1'b0}});
  assign w_pop       = w_out_valid & i_out_ready;
  assign w_entry     = f_collect(r_div_a, r_div_b, i_div_q, i_div_r);
  assign w_head      = r_mem[r_rd_ptr];

  // Issue register: operands to the divider and the in-flight flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_div_a    <= 4'd0;
      r_div_b    <= 4'd0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_div_a    <= i_in_a;
      r_div_b    <= i_in_b;
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  // Divide-by-zero event counter, saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dbz_cnt <= {CNT_W{1'b0}};
    end else if (w_accept && (i_in_b == 4'd0)) begin
      r_dbz_cnt <= f_sat_inc(r_dbz_cnt);
    end else begin
      r_dbz_cnt <= r_dbz_cnt;
    end
  end

  // FIFO storage; contents need no reset because reads are gated by count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {OCC_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Show-ahead head; forced to zero while empty so stale entries never leak.
  always_comb begin
    o_out_q   = 4'd0;
    o_out_r   = 4'd0;
    o_out_dbz = 1'b0;
    if (w_out_valid) begin
      o_out_q   = w_head[8:5];
      o_out_r   = w_head[4:1];
      o_out_dbz = w_head[0];
    end else begin
      o_out_q   = 4'd0;
      o_out_r   = 4'd0;
      o_out_dbz = 1'b0;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_div_a     = r_div_a;
  assign o_div_b     = r_div_b;
  assign o_out_valid = w_out_valid;
  assign o_dbz_cnt   = r_dbz_cnt;

  div4_issue_stage_chk #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_chk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_count (r_count)
  );

endmodule

// -----------------------------------------------------------------------------
// div4_issue_stage_chk
//   Invariant checker for the result FIFO: a push must never land on a full
//   FIFO unless a pop frees the slot on the same edge.
// Ports
//   i_clk, i_rst_n  clock and async active-low reset
//   i_push, i_pop   FIFO write / read strobes
//   i_count         current FIFO occupancy
// -----------------------------------------------------------------------------
module div4_issue_stage_chk #(
  parameter int DEPTH = 4,
  parameter int OCC_W = 3
) (
  input logic             i_clk,
  input logic             i_rst_n,
  input logic             i_push,
  input logic             i_pop,
  input logic [OCC_W-1:0] i_count
);

  localparam logic [OCC_W-1:0] FULL_C = OCC_W'(DEPTH);

  // Flag a push into a full FIFO with no simultaneous pop.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(i_push && !i_pop && (i_count == FULL_C)))
        else $error("div4_issue_stage: push into full result FIFO");
    end
  end

endmodule

// File: tb/tb_div4_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_div4_issue_stage
//   Directed bench for div4_issue_stage. A behavioural divider drives the
//   divider inputs (with a deliberately bogus result for divisor 0). Expected
//   results are pushed into a queue when a pair is accepted; a monitor pops
//   and compares whenever the DUT hands over a result.
// -----------------------------------------------------------------------------
module tb_div4_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_a = 4'd0;
  logic [3:0] in_b = 4'd0;
  logic       in_ready;
  logic [3:0] div_a, div_b, div_q, div_r;
  logic       out_valid, out_dbz;
  logic [3:0] out_q, out_r;
  logic [7:0] dbz_cnt;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  div4_issue_stage #(.DEPTH(4), .CNT_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_a      (in_a),
    .i_in_b      (in_b),
    .o_div_a     (div_a),
    .o_div_b     (div_b),
    .i_div_q     (div_q),
    .i_div_r     (div_r),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_q     (out_q),
    .o_out_r     (out_r),
    .o_out_dbz   (out_dbz),
    .o_dbz_cnt   (dbz_cnt)
  );

  always #5 clk = ~clk;

  // External divider model; divisor 0 yields junk the stage must ignore.
  always_comb begin
    if (div_b != 4'd0) begin
      div_q = div_a / div_b;
      div_r = div_a % div_b;
    end else begin
      div_q = 4'h5;
      div_r = 4'hA;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair until accepted; queue its expected result at acceptance.
  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] q, input logic [3:0] r, input logic d);
    bit acc;
    int waited;
    acc = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!acc && waited < 64) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back({q, r, d});
      end
      tick();
      if (!acc) waited++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted a=%0d b=%0d", a, b);
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: compare every handed-over result with the queue head.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=%0h required=none", {out_q, out_r, out_dbz});
        end else begin
          e = exp_q.pop_front();
          check("sb_result", {out_q, out_r, out_dbz}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] t3a [5];
    logic [3:0] t3b [5];
    logic [3:0] t3q [5];
    logic [3:0] t3r [5];
    logic       t3d [5];
    int acc;
    logic [3:0] av;

    t3a = '{4'd10, 4'd6, 4'd14, 4'd5, 4'd11};
    t3b = '{4'd3,  4'd4, 4'd7,  4'd0, 4'd2};
    t3q = '{4'd3,  4'd1, 4'd2,  4'hF, 4'd5};
    t3r = '{4'd1,  4'd2, 4'd0,  4'd5, 4'd1};
    t3d = '{1'b0,  1'b0, 1'b0,  1'b1, 1'b0};

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_qr", {out_q, out_r, out_dbz}, 9'd0);
    check("rst_dbz_cnt", dbz_cnt, 8'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_div_ab", {div_a, div_b}, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: 13/3 with one-cycle collect latency
    out_ready = 1'b1;
    send(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    @(negedge clk);
    check("t1_not_early", out_valid, 1'b0);
    @(negedge clk);
    check("t1_latency", out_valid, 1'b1);
    tick(); tick(); tick();

    // T2: divide by zero, then 15/1
    send(4'd9, 4'd0, 4'hF, 4'd9, 1'b1);
    check("t2_dbz_cnt", dbz_cnt, 8'd1);
    send(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    tick(); tick(); tick();
    check("t2_div_ab_hold", {div_a, div_b}, {4'd15, 4'd1});

    // T3: backpressure fills exactly DEPTH slots
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_a = t3a[acc];
      in_b = t3b[acc];
      @(negedge clk);
      if (in_ready && acc < 5) begin
        exp_q.push_back({t3q[acc], t3r[acc], t3d[acc]});
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("t3_accepts", acc, 4);
    @(negedge clk);
    check("t3_full_ready", in_ready, 1'b0);
    check("t3_dbz_cnt", dbz_cnt, 8'd2);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_still_full", in_ready, 1'b0);
    @(negedge clk);
    check("t3_recover", in_ready, 1'b1);
    repeat (6) tick();

    // T4: back-to-back stream at full rate
    fork
      begin
        send(4'd7,  4'd2, 4'd3, 4'd1, 1'b0);
        send(4'd8,  4'd8, 4'd1, 4'd0, 1'b0);
        send(4'd0,  4'd5, 4'd0, 4'd0, 1'b0);
        send(4'd15, 4'd4, 4'd3, 4'd3, 1'b0);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i < 4) check("t4_in_ready", in_ready, 1'b1);
          if (i >= 2) check("t4_out_valid", out_valid, 1'b1);
        end
      end
    join
    repeat (4) tick();

    // T5: full with in-flight pair, head held, then push+pop on one edge
    out_ready = 1'b0;
    send(4'd9,  4'd4,  4'd2, 4'd1, 1'b0);
    send(4'd13, 4'd13, 4'd1, 4'd0, 1'b0);
    send(4'd3,  4'd7,  4'd0, 4'd3, 1'b0);
    send(4'd15, 4'd2,  4'd7, 4'd1, 1'b0);
    @(negedge clk);
    check("t5_full_inflight", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_hold_valid", out_valid, 1'b1);
      check("t5_hold_head", {out_q, out_r, out_dbz}, {4'd2, 4'd1, 1'b0});
    end
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 4'd12;
    in_b = 4'd5;
    @(negedge clk);
    check("t5_full_ready", in_ready, 1'b0);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("t5_slot_freed", in_ready, 1'b1);
    exp_q.push_back({4'd2, 4'd2, 1'b0});
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_reserved", in_ready, 1'b0);
    tick();
    @(negedge clk);
    check("t5_pushpop_ready", in_ready, 1'b1);
    check("t5_pushpop_valid", out_valid, 1'b1);
    repeat (8) tick();

    // T6: asynchronous reset with entries queued
    out_ready = 1'b0;
    send(4'd4, 4'd2, 4'd2, 4'd0, 1'b0);
    send(4'd6, 4'd0, 4'hF, 4'd6, 1'b1);
    send(4'd7, 4'd3, 4'd2, 4'd1, 1'b0);
    tick(); tick();
    check("t6_dbz_before", dbz_cnt, 8'd3);
    check("t6_valid_before", out_valid, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_dbz_cnt", dbz_cnt, 8'd0);
    check("t6_in_ready", in_ready, 1'b1);
    check("t6_out_qr", {out_q, out_r, out_dbz}, 9'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("t6_no_partial", out_valid, 1'b0);
    tick();

    // Saturation of the divide-by-zero counter
    for (int i = 0; i < 255; i++) begin
      av = 4'(i);
      send(av, 4'd0, 4'hF, av, 1'b1);
    end
    check("sat_reach", dbz_cnt, 8'd255);
    for (int i = 0; i < 5; i++) begin
      av = 4'(i + 3);
      send(av, 4'd0, 4'hF, av, 1'b1);
    end
    check("sat_hold", dbz_cnt, 8'd255);
    repeat (4) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
